// File: rtl/heartbeat_pkg.sv
// Shared types and default constants for the tt_um_heartbeat beat monitor.
package heartbeat_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCKOUT,
    ARMED
  } hb_state_e;

  localparam int unsigned INTERVAL_W   = 12;
  localparam int unsigned INTERVAL_MAX = 4095;

  localparam int unsigned TICK_DIV_DEF   = 10000;
  localparam int unsigned DEBOUNCE_N_DEF = 4;
  localparam int unsigned REFRACT_MS_DEF = 200;
  localparam int unsigned TACHY_MS_DEF   = 400;
  localparam int unsigned BRADY_MS_DEF   = 1500;
  localparam int unsigned TIMEOUT_MS_DEF = 3000;
  localparam int unsigned LED_MS_DEF     = 100;

endpackage

// File: rtl/beat_debounce.sv
// Synchroniser, ms-tick debouncer and registered rising-edge beat event.
module beat_debounce #(
  parameter int unsigned DEBOUNCE_N = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic tick,
  input  logic raw,
  output logic beat
);

  localparam int unsigned RW = (DEBOUNCE_N > 1) ? $clog2(DEBOUNCE_N) : 1;

  logic [1:0]    sync_q;
  logic          level_q;
  logic [RW-1:0] run_q;

  // run_q counts consecutive tick samples that disagree with the debounced level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      run_q   <= '0;
      beat    <= 1'b0;
    end else if (ena) begin
      sync_q <= {sync_q[0], raw};
      beat   <= 1'b0;
      if (tick) begin
        if (sync_q[1] != level_q) begin
          if (run_q == RW'(DEBOUNCE_N - 1)) begin
            level_q <= sync_q[1];
            run_q   <= '0;
            beat    <= sync_q[1];
          end else begin
            run_q <= run_q + 1'b1;
          end
        end else begin
          run_q <= '0;
        end
      end
    end
  end

endmodule

// File: rtl/beat_monitor.sv
// Beat-interval monitor: prescaler, lockout FSM, interval measurement and rate alarms.
// Optional beat LED stretch is built when BEAT_MONITOR_LED_EN is defined.
module beat_monitor
  import heartbeat_pkg::*;
#(
  parameter int unsigned TICK_DIV   = TICK_DIV_DEF,
  parameter int unsigned DEBOUNCE_N = DEBOUNCE_N_DEF,
  parameter int unsigned REFRACT_MS = REFRACT_MS_DEF,
  parameter int unsigned TACHY_MS   = TACHY_MS_DEF,
  parameter int unsigned BRADY_MS   = BRADY_MS_DEF,
  parameter int unsigned TIMEOUT_MS = TIMEOUT_MS_DEF,
  parameter int unsigned LED_MS     = LED_MS_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  beat_in,
  output logic [INTERVAL_W-1:0] interval_o,
  output logic                  interval_valid,
  output logic                  tachy,
  output logic                  brady,
  output logic                  asystole,
  output logic [7:0]            beat_count,
  output logic                  beat_led
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [INTERVAL_W-1:0] CNT_MAX   = INTERVAL_W'(INTERVAL_MAX);
  localparam logic [INTERVAL_W-1:0] REFRACT_C = INTERVAL_W'(REFRACT_MS);
  localparam logic [INTERVAL_W-1:0] TACHY_C   = INTERVAL_W'(TACHY_MS);
  localparam logic [INTERVAL_W-1:0] BRADY_C   = INTERVAL_W'(BRADY_MS);
  localparam logic [INTERVAL_W-1:0] TIMEOUT_C = INTERVAL_W'(TIMEOUT_MS);

  logic [PW-1:0]         presc_q;
  logic                  tick;
  logic                  beat;
  hb_state_e             state_q, state_d;
  logic [INTERVAL_W-1:0] cnt_q;
  logic                  accept;
  logic                  measure;
  logic                  timeout;

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else if (ena) begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

  beat_debounce #(
    .DEBOUNCE_N(DEBOUNCE_N)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .ena  (ena),
    .tick (tick),
    .raw  (beat_in),
    .beat (beat)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    measure = 1'b0;
    timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) begin
          accept  = 1'b1;
          state_d = LOCKOUT;
        end
      end
      LOCKOUT: begin
        if (cnt_q >= REFRACT_C) state_d = ARMED;
      end
      ARMED: begin
        if (beat) begin
          accept  = 1'b1;
          measure = 1'b1;
          state_d = LOCKOUT;
        end else if (cnt_q >= TIMEOUT_C) begin
          timeout = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // An accepted beat restarts the counter and swallows a coincident tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      interval_o     <= '0;
      interval_valid <= 1'b0;
      tachy          <= 1'b0;
      brady          <= 1'b0;
      asystole       <= 1'b0;
      beat_count     <= '0;
    end else if (!ena) begin
      interval_valid <= 1'b0;
    end else begin
      state_q        <= state_d;
      interval_valid <= 1'b0;
      if (accept) begin
        cnt_q <= '0;
      end else if (tick && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (accept) begin
        beat_count <= beat_count + 1'b1;
        asystole   <= 1'b0;
      end
      if (measure) begin
        interval_o     <= cnt_q;
        interval_valid <= 1'b1;
        tachy          <= (cnt_q < TACHY_C);
        brady          <= (cnt_q > BRADY_C);
      end
      if (timeout) asystole <= 1'b1;
    end
  end

`ifdef BEAT_MONITOR_LED_EN
  localparam int unsigned LW = (LED_MS > 1) ? $clog2(LED_MS) : 1;

  logic [LW-1:0] led_cnt_q;
  logic          led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q     <= 1'b0;
      led_cnt_q <= '0;
    end else if (ena) begin
      if (accept) begin
        led_q     <= 1'b1;
        led_cnt_q <= '0;
      end else if (led_q && tick) begin
        if (led_cnt_q == LW'(LED_MS - 1)) begin
          led_q <= 1'b0;
        end else begin
          led_cnt_q <= led_cnt_q + 1'b1;
        end
      end
    end
  end

  assign beat_led = led_q;
`else
  logic unused_led_ms;
  assign unused_led_ms = (LED_MS != 0);
  assign beat_led      = 1'b0;
`endif

endmodule
